jh512_padder: RTL and testbench
===============================

JH512_PADDER -- requirements
Module: jh512_padder

Interface
REQ-001 Parameters: none; widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_data  input  64  message word; first byte in [63:56].
REQ-005 in_bytes  input  4  valid bytes in in_data, left-aligned; 8 except on the last word; 0 legal only with in_last (empty-message tail).
REQ-006 in_last  input  1  word is the final word of the message.
REQ-007 in_valid / in_ready  input / output  1 each  upstream handshake; a word transfers on a clk edge where both are high.
REQ-008 out_block  output  512  padded JH512 block; byte 0 in [511:504].
REQ-009 out_last  output  1  block is the final block of the message.
REQ-010 out_valid / out_ready  output / input  1 each  downstream handshake toward the JH512 core.

Function
REQ-011 Padding: append bit 1, then 383 + (-L mod 512) zero bits, then L as a 128-bit big-endian count; L = message length in bits.
REQ-012 Length counter: 64-bit byte count; L = count*8 placed in out_block[127:0], with [127:67] = 0 from the upper zero-extension.
REQ-013 States: FILL, EMIT, TAIL, FINAL.
REQ-014 FILL: in_ready=1, out_valid=0; accepted word written to word slot idx (0..7, slot 0 = [511:448]); idx increments; count += in_bytes.
REQ-015 FILL, word accepted with idx=7 and in_last=0 -> EMIT (out_last=0); idx wraps to 0.
REQ-016 FILL, in_last accepted, (count+in_bytes) mod 64 != 0 -> 0x80 written at the byte after the last valid byte; all later bytes in the block zeroed -> TAIL (out_last=0).
REQ-017 FILL, in_last accepted, (count+in_bytes) mod 64 == 0 and count+in_bytes > 0 -> EMIT the full message block (out_last=0), then FINAL.
REQ-018 FILL, in_last with in_bytes=0 at idx=0 (empty message, or boundary-aligned tail) -> FINAL directly.
REQ-019 FINAL block: byte 0 = 0x80, zeros, length in [127:0]; out_last=1.
REQ-020 After TAIL handshake -> length block: all zeros except length in [127:0]; out_last=1.
REQ-021 out_valid asserts the cycle after the accepting edge; out_block and out_last hold stable while out_valid=1 and out_ready=0.
REQ-022 in_ready=0 in EMIT, TAIL, FINAL and the length-block phase; no input is accepted while out_valid=1.
REQ-023 Final block handshake -> count, idx and buffer cleared -> FILL; the next message starts in the following cycle.
REQ-024 Throughput: 8 input cycles + 1 output cycle per full block when out_ready=1.
REQ-025 in_bytes > 8, or in_bytes != 8 without in_last: behaviour undefined; the bench shall not drive it.

Reset
REQ-026 rst=1 at a clk edge: state=FILL, idx=0, count=0, buffer=0, out_valid=0, out_last=0, out_block=0; in_ready=1 from the next cycle.
REQ-027 Reset mid-message or mid-output discards all partial data; no block is emitted for the aborted message.

Verification
REQ-028 Empty message: in_last=1, in_bytes=0 -> one block, 0x80 at [511:504], all else 0, out_last=1.
REQ-029 "abc" (in_data=0x6162630000000000, in_bytes=3, last) -> block 1: 0x61626380 then zeros, out_last=0; block 2: [127:0]=24, rest 0, out_last=1.
REQ-030 Exactly 64 bytes (8 full words) -> message block unchanged, out_last=0; then 0x80 block with [127:0]=512, out_last=1.
REQ-031 100 bytes (12 words + 4-byte tail) -> full block, tail block with 0x80 at byte 36, length block [127:0]=800.
REQ-032 out_ready held 0 for 5 cycles on each block -> out_block stable, in_ready=0 throughout; no data loss.
REQ-033 rst asserted after 5 words of a message -> outputs zero; a new "abc" message then yields exactly the REQ-029 blocks.

Source files
------------

// File: rtl/jh512_padder.sv
// jh512_padder
//   Turns a stream of 64-bit message words into padded 512-bit JH512 blocks.
//   Padding appends a 1 bit, zero bits, and a 128-bit big-endian bit length.
//   When the message leaves room in its last block, the 0x80 marker closes that
//   block and a separate length-only block follows. When the message ends
//   exactly on a block boundary, a block holding 0x80 and the length follows.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    message word, first byte in [63:56]
//   in_bytes   valid bytes in in_data (left-aligned), 0..8
//   in_last    final word of the message
//   in_valid   upstream word valid
//   in_ready   padder can take a word (only while filling)
//   out_block  padded block, byte 0 in [511:504]
//   out_last   block is the final block of the message
//   out_valid  block valid toward the JH512 core
//   out_ready  core accepts the block
module jh512_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  in_data,
  input  logic [3:0]   in_bytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_block,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {FILL, EMIT, TAIL, FINAL} state_t;

  state_t       state, state_nxt;
  logic [2:0]   idx;
  logic [63:0]  count;
  logic [511:0] blk;
  logic         pend_final;

  logic         in_acc;
  logic [63:0]  count_nxt;
  logic [511:0] blk_wr;

  // Place 0x80 at byte position pos and clear every byte after it.
  function automatic logic [511:0] pad_block(input logic [511:0] b, input logic [5:0] pos);
    logic [511:0] r;
    r = b;
    for (int i = 0; i < 64; i++) begin
      if (i == int'(pos))
        r[(63 - i)*8 +: 8] = 8'h80;
      else if (i > int'(pos))
        r[(63 - i)*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  // Closing block: optional leading 0x80, bit length (bytes*8) in [127:0].
  function automatic logic [511:0] len_block(input logic [63:0] c, input logic mark);
    logic [511:0] r;
    r = '0;
    r[511:504] = mark ? 8'h80 : 8'h00;
    r[66:3] = c;
    return r;
  endfunction

  assign in_ready  = (state == FILL);
  assign out_valid = (state != FILL);
  assign out_last  = (state == FINAL);
  assign out_block = blk;

  assign in_acc    = in_valid & in_ready;
  assign count_nxt = count + {60'd0, in_bytes};

  always_comb begin
    blk_wr = blk;
    blk_wr[(7 - int'(idx))*64 +: 64] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (in_acc) begin
          if (in_last) begin
            if (count_nxt[5:0] != 6'd0) state_nxt = TAIL;
            // A zero-byte last word only arrives on a block boundary.
            else if (in_bytes == 4'd0)  state_nxt = FINAL;
            else                        state_nxt = EMIT;
          end else if (idx == 3'd7) begin
            state_nxt = EMIT;
          end
        end
      end
      EMIT:  if (out_ready) state_nxt = pend_final ? FINAL : FILL;
      TAIL:  if (out_ready) state_nxt = FINAL;
      FINAL: if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 3'd0;
      count      <= 64'd0;
      blk        <= '0;
      pend_final <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_acc) begin
            count <= count_nxt;
            idx   <= idx + 3'd1;
            if (in_last) begin
              if (count_nxt[5:0] != 6'd0) begin
                blk <= pad_block(blk_wr, count_nxt[5:0]);
              end else if (in_bytes == 4'd0) begin
                blk <= len_block(count_nxt, 1'b1);
              end else begin
                blk        <= blk_wr;
                pend_final <= 1'b1;
              end
            end else begin
              blk <= blk_wr;
            end
          end
        end
        EMIT: begin
          // Stale slots are overwritten word by word during the next fill.
          if (out_ready && pend_final) begin
            blk        <= len_block(count, 1'b1);
            pend_final <= 1'b0;
          end
        end
        TAIL: begin
          if (out_ready) blk <= len_block(count, 1'b0);
        end
        FINAL: begin
          if (out_ready) begin
            blk        <= '0;
            count      <= 64'd0;
            idx        <= 3'd0;
            pend_final <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jh512_padder.sv
module tb_jh512_padder;

  typedef logic [511:0] blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  in_data;
  logic [3:0]   in_bytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  blk_t exp_blk[$];
  logic exp_last[$];
  bit   stall = 1'b0;

  jh512_padder dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_block(out_block), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Message byte k for a given seed; seed 0 is the string "abc".
  function automatic logic [7:0] gb(input int seed, input int k);
    if (seed == 0) return 8'h61 + 8'(k);
    return 8'((seed * 31 + k * 13 + 1) & 255);
  endfunction

  // Reference padding: message bytes, 0x80, 47 zero bytes, (-n mod 64)
  // zero bytes, 16-byte big-endian bit length, then cut into 64-byte blocks.
  function automatic void mk(input int n, input int seed, output blk_t bq[$]);
    logic [7:0]   p[$];
    logic [127:0] lbits;
    blk_t         b;
    bq = {};
    for (int k = 0; k < n; k++) p.push_back(gb(seed, k));
    p.push_back(8'h80);
    repeat (47) p.push_back(8'h00);
    repeat ((64 - n % 64) % 64) p.push_back(8'h00);
    lbits = 128'(n) * 128'd8;
    for (int i = 15; i >= 0; i--) p.push_back(lbits[i*8 +: 8]);
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) b[(63 - j)*8 +: 8] = p[bi*64 + j];
      bq.push_back(b);
    end
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int t;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    n_assert++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input int n, input int seed, input bit tail0);
    blk_t bq[$];
    int nw;
    bit extra;
    logic [63:0] d;
    int nb;
    mk(n, seed, bq);
    foreach (bq[i]) begin
      exp_blk.push_back(bq[i]);
      exp_last.push_back(i == bq.size() - 1);
    end
    nw = (n + 7) / 8;
    extra = (n == 0) || (n % 8 == 0 && tail0);
    for (int w = 0; w < nw; w++) begin
      nb = (n - 8*w > 8) ? 8 : n - 8*w;
      d = '0;
      for (int j = 0; j < nb; j++) d[(7 - j)*8 +: 8] = gb(seed, 8*w + j);
      send_word(d, 4'(nb), !extra && (w == nw - 1));
    end
    if (extra) send_word(64'd0, 4'd0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_blk.size() != 0 && t < 1000) begin
      t++;
      @(posedge clk);
    end
    #1;
    chk("drain_pending_blocks", 512'(exp_blk.size()), 512'd0);
  endtask

  // out_ready: always 1, or held low 5 cycles for every block when stalling.
  initial begin
    int hold = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall) begin
        out_ready = 1'b1;
        hold = 0;
      end else if (!out_valid) begin
        out_ready = 1'b0;
        hold = 0;
      end else if (hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
        hold = 0;
      end
    end
  end

  // Compare process: checks every output block against the reference queue,
  // stability during backpressure, and that input is blocked while output is valid.
  initial begin
    blk_t held_blk;
    logic held_last;
    bit   held = 1'b0;
    blk_t eb;
    logic el;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (held) begin
          chk("stall_valid", 512'(out_valid), 512'd1);
          chk("stall_block", out_block, held_blk);
          chk("stall_last", 512'(out_last), 512'(held_last));
        end
        if (out_valid) chk("in_ready_blocked", 512'(in_ready), 512'd0);
        held = 1'b0;
        if (out_valid && !out_ready) begin
          held = 1'b1;
          held_blk = out_block;
          held_last = out_last;
        end
        if (out_valid && out_ready) begin
          if (exp_blk.size() == 0) begin
            chk("unexpected_block", out_block, 512'd0);
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_block: got block with none required");
          end else begin
            eb = exp_blk.pop_front();
            el = exp_last.pop_front();
            chk("out_block", out_block, eb);
            chk("out_last", 512'(out_last), 512'(el));
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    blk_t bq[$];
    blk_t lit;
    rst = 1'b1;
    in_data = '0;
    in_bytes = '0;
    in_last = 1'b0;
    in_valid = 1'b0;

    // Pin the reference model against hand-computed blocks.
    mk(0, 0, bq);
    chk("pin_empty_n", 512'(bq.size()), 512'd1);
    chk("pin_empty", bq[0], {8'h80, 504'd0});
    mk(3, 0, bq);
    chk("pin_abc_b0", bq[0], {32'h61626380, 480'd0});
    chk("pin_abc_b1", bq[1], 512'd24);
    mk(64, 1, bq);
    lit = {8'h80, 376'd0, 128'd512};
    chk("pin_64_b1", bq[1], lit);
    mk(100, 3, bq);
    chk("pin_100_n", 512'(bq.size()), 512'd3);
    chk("pin_100_mark", 512'(bq[1][511 - 36*8 -: 8]), 512'h80);
    chk("pin_100_len", bq[2], 512'd800);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_out_last", 512'(out_last), 512'd0);
    chk("rst_out_block", out_block, 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;

    send_msg(0, 0, 1'b0);     // empty message
    send_msg(3, 0, 1'b0);     // "abc"
    send_msg(64, 1, 1'b0);    // aligned, last flag on 8th word
    send_msg(64, 2, 1'b1);    // aligned, separate zero-byte tail word
    send_msg(100, 3, 1'b0);   // full block + 4-byte tail
    send_msg(16, 4, 1'b0);    // marker lands in the first byte of slot 2
    send_msg(120, 5, 1'b0);   // tail block with marker in the last word
    drain();

    stall = 1'b1;
    send_msg(3, 0, 1'b0);
    send_msg(100, 6, 1'b0);
    send_msg(64, 7, 1'b0);
    drain();
    stall = 1'b0;

    // Abort a message after 5 words; nothing may be emitted for it.
    for (int w = 0; w < 5; w++) send_word(64'h0102030405060708 + 64'(w), 4'd8, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_out_valid", 512'(out_valid), 512'd0);
    chk("abort_out_block", out_block, 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;
    send_msg(3, 0, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
